// File: rtl/text_ram_writer_if.sv
// Command handshake between game logic and the text RAM writer.
// Game logic drives the master side; the writer is the slave.
interface text_ram_writer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/text_ram_writer.sv
// Write-side controller for the tile/text RAM: cursor writes, clear and fill sequences.
// Define TEXT_RAM_WRITER_CLEAR_ON_RESET_EN to run a full clear after every reset release.
module text_ram_writer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    text_ram_writer_if.slave      cmd,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] din_a,
    output logic [ADDR_WIDTH-1:0] cursor,
    output logic                  busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_FILL  = 2'b10
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SETCUR = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_FILL   = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

`ifdef TEXT_RAM_WRITER_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t                state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic [DATA_WIDTH-1:0] fill_data_r, fill_data_nxt_s;
    logic [ADDR_WIDTH-1:0] cursor_r, cursor_nxt_s;
    logic                  we_r, we_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
    logic [DATA_WIDTH-1:0] din_r, din_nxt_s;
    logic                  accept_s;

    assign cmd.cmd_ready = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
    assign we            = we_r;
    assign addr_a        = addr_r;
    assign din_a         = din_r;
    assign cursor        = cursor_r;

    // Next-state and next-output logic; the RAM port is only ever driven from registers.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        fill_data_nxt_s = fill_data_r;
        cursor_nxt_s    = cursor_r;
        we_nxt_s        = 1'b0;
        addr_nxt_s      = addr_r;
        din_nxt_s       = din_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_WRITE: begin
                            we_nxt_s     = 1'b1;
                            addr_nxt_s   = cursor_r;
                            din_nxt_s    = cmd.cmd_data;
                            cursor_nxt_s = cursor_r + ADDR_ONE;
                        end
                        OP_SETCUR: begin
                            cursor_nxt_s = cmd.cmd_addr;
                        end
                        OP_CLEAR: begin
                            state_nxt_s = ST_CLEAR;
                            cnt_nxt_s   = ADDR_ZERO;
                        end
                        OP_FILL: begin
                            state_nxt_s     = ST_FILL;
                            cnt_nxt_s       = cmd.cmd_addr;
                            fill_data_nxt_s = cmd.cmd_data;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = cnt_r;
                din_nxt_s  = CLEAR_CHAR;
                // Terminate on an explicit last-address compare, never on wrap to zero.
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s  = ST_IDLE;
                    cursor_nxt_s = ADDR_ZERO;
                    cnt_nxt_s    = ADDR_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + ADDR_ONE;
                end
            end
            ST_FILL: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = cnt_r;
                din_nxt_s  = fill_data_r;
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = ADDR_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + ADDR_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, sequence counter, cursor and registered RAM write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RESET_STATE;
            cnt_r       <= ADDR_ZERO;
            fill_data_r <= DATA_ZERO;
            cursor_r    <= ADDR_ZERO;
            we_r        <= 1'b0;
            addr_r      <= ADDR_ZERO;
            din_r       <= DATA_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            fill_data_r <= fill_data_nxt_s;
            cursor_r    <= cursor_nxt_s;
            we_r        <= we_nxt_s;
            addr_r      <= addr_nxt_s;
            din_r       <= din_nxt_s;
        end
    end
endmodule

// File: tb/tb_text_ram_writer.sv
// Self-checking bench for text_ram_writer: directed and random commands against a
// RAM-image and write-list reference model.
module tb_text_ram_writer;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam logic [7:0] CCHAR = 8'h20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic [AW-1:0] cursor;
    logic          busy;

    text_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    text_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_CHAR(CCHAR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd     (bus),
        .we      (we),
        .addr_a  (addr_a),
        .din_a   (din_a),
        .cursor  (cursor),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    int          obs_cyc_q[$];
    logic [7:0]  ref_mem[DEPTH];
    logic [7:0]  tb_ram[DEPTH];
    int          ref_cursor;

    always @(posedge clk) cyc++;

    // RAM image as the RAM itself would capture it, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_q.push_back({addr_a, din_a});
            obs_cyc_q.push_back(cyc);
            tb_ram[addr_a] = din_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_write(input int a, input logic [7:0] d);
        logic [5:0] a6;
        a6 = a[5:0];
        exp_q.push_back({a6, d});
        ref_mem[a6] = d;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic flush();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("ready_timeout", bus.cmd_ready, 1);
    endtask

    // Holds cmd_valid with junk commands while busy; returns cycles with cmd_ready low.
    task automatic hold_busy(input logic [1:0] hop, input logic [7:0] hdata, output int n);
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = hop;
        bus.cmd_data  = hdata;
        while (n < 300) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) break;
            bus.cmd_addr = 6'($urandom);
            n++;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic op_write(input logic [7:0] d);
        wait_ready();
        bus.cmd_op = 2'b00; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        model_write(ref_cursor, d);
        ref_cursor = (ref_cursor + 1) % DEPTH;
        chk("write_cursor", cursor, ref_cursor);
    endtask

    task automatic op_setcur(input logic [5:0] a);
        wait_ready();
        bus.cmd_op = 2'b01; bus.cmd_addr = a; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        ref_cursor = a;
        chk("setcur_cursor", cursor, ref_cursor);
    endtask

    task automatic op_clear();
        int n;
        wait_ready();
        bus.cmd_op = 2'b10; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) model_write(i, CCHAR);
        ref_cursor = 0;
        hold_busy(2'b00, 8'($urandom), n);
        chk("clear_busy_cycles", n, DEPTH);
        flush();
        chk("clear_cursor", cursor, ref_cursor);
        check_writes("clear");
    endtask

    task automatic op_fill(input logic [5:0] a, input logic [7:0] d, input logic [7:0] later_d);
        int n;
        wait_ready();
        bus.cmd_op = 2'b11; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = a; i < DEPTH; i++) model_write(i, d);
        hold_busy(2'($urandom), later_d, n);
        chk("fill_busy_cycles", n, DEPTH - int'(a));
        flush();
        chk("fill_cursor", cursor, ref_cursor);
        check_writes("fill");
    endtask

    task automatic release_reset();
        int n;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef TEXT_RAM_WRITER_CLEAR_ON_RESET_EN
        hold_busy(2'b00, 8'h00, n);
        chk("por_busy_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) model_write(i, CCHAR);
        ref_cursor = 0;
        flush();
        check_writes("por_clear");
`else
        n = 0;
        chk("reset_ready", bus.cmd_ready, 1);
`endif
    endtask

    initial begin
        logic [7:0] abc[3];
        int n;
        logic [3:0] r;
        abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 8'h00;
            tb_ram[i]  = 8'h00;
        end
        ref_cursor    = 0;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 6'd0;
        bus.cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", we, 0);
        chk("reset_addr", addr_a, 0);
        chk("reset_din", din_a, 0);
        chk("reset_cursor", cursor, 0);
        release_reset();
        chk("post_reset_cursor", cursor, 0);
        chk("post_reset_we", we, 0);

        // Back-to-back writes across the wrap point.
        op_setcur(6'd62);
        bus.cmd_op = 2'b00;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cmd_data = abc[i];
            chk("b2b_ready", bus.cmd_ready, 1);
            @(posedge clk);
            #1;
            model_write(ref_cursor, abc[i]);
            ref_cursor = (ref_cursor + 1) % DEPTH;
        end
        bus.cmd_valid = 1'b0;
        flush();
        chk("b2b_cursor", cursor, 1);
        if (obs_cyc_q.size() == 3) begin
            chk("b2b_gap0", obs_cyc_q[1] - obs_cyc_q[0], 1);
            chk("b2b_gap1", obs_cyc_q[2] - obs_cyc_q[1], 1);
        end else begin
            chk("b2b_write_slots", obs_cyc_q.size(), 3);
        end
        check_writes("b2b");

        op_clear();

        // Fill near the top with data changed while busy; then single-word fill.
        op_setcur(6'd5);
        op_fill(6'd60, 8'h2A, 8'h55);
        op_fill(6'd63, 8'h77, 8'h11);

        // Random command mix.
        for (int k = 0; k < 40; k++) begin
            r = 4'($urandom_range(0, 9));
            if (r < 4'd6)       op_write(8'($urandom));
            else if (r < 4'd8)  op_setcur(6'($urandom));
            else if (r == 4'd8) op_fill(6'($urandom_range(32, 63)), 8'($urandom), 8'($urandom));
            else                op_write(8'($urandom));
        end
        flush();
        check_writes("random");

        // Asynchronous reset in the middle of a clear, counter at 20.
        wait_ready();
        bus.cmd_op = 2'b10; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_we", we, 0);
        for (int i = 0; i < 19; i++) model_write(i, CCHAR);
        ref_cursor = 0;
        repeat (2) @(posedge clk);
        release_reset();
        flush();
        chk("abort_cursor", cursor, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        check_writes("abort");

        for (int i = 0; i < DEPTH; i++) chk("ram_image", tb_ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_ram_writer.md
Name: text_ram_writer

Overview:
- Write-side controller for the dual-port tile/text RAM.
- Accepts character commands from game logic over a valid/ready handshake and drives the RAM write port (we, addr_a, din_a) with registered outputs.
- Maintains an auto-incrementing cursor and runs multi-cycle clear and fill sequences.
- The video scanner owns the RAM read port; this block never reads.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- CLEAR_CHAR, 0, word written to every location by the clear sequence.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  00 WRITE, 01 SETCUR, 10 CLEAR, 11 FILL.
- cmd_addr  input  ADDR_WIDTH  cursor value (SETCUR) or start address (FILL).
- cmd_data  input  DATA_WIDTH  character (WRITE, FILL).
- we  output  1  RAM write enable.
- addr_a  output  ADDR_WIDTH  RAM write address.
- din_a  output  DATA_WIDTH  RAM write data.
- cursor  output  ADDR_WIDTH  current cursor.
- busy  output  1  multi-cycle sequence in progress.

Behaviour:
- States: IDLE, CLEAR, FILL.
- cmd_ready = (state == IDLE), combinational from state. busy = !cmd_ready.
- A command is accepted on a rising edge with cmd_valid && cmd_ready. Inputs are ignored otherwise.
- Reset (async assert, any state):
  - we=0, addr_a=0, din_a=0, cursor=0, state=IDLE.
  - Any clear or fill in progress is aborted; no partial write is completed.
- we, addr_a and din_a are registered. A write caused by a command accepted at edge N is presented during cycle N..N+1 and captured by the RAM at edge N+1.
- we defaults to 0 in any cycle with no scheduled write.
- WRITE:
  - Next cycle: we=1, addr_a=cursor, din_a=cmd_data; cursor <= cursor+1, modulo 2**ADDR_WIDTH (last address wraps to 0).
  - Stays in IDLE, so back-to-back WRITEs sustain one write per cycle.
- SETCUR: cursor <= cmd_addr; no write; stays in IDLE.
- CLEAR:
  - Enter CLEAR with an internal counter at 0.
  - Each cycle: we=1, addr_a=counter, din_a=CLEAR_CHAR, counter+1.
  - After the write to the last address (2**ADDR_WIDTH-1), return to IDLE and set cursor=0.
  - Exactly 2**ADDR_WIDTH writes; cmd_ready low for exactly 2**ADDR_WIDTH cycles after acceptance.
- FILL:
  - Enter FILL with the counter at cmd_addr and data latched from cmd_data.
  - Write the latched data at counter, counter+1, ..., up to and including the last address; no wrap.
  - Then return to IDLE. Cursor is unchanged.
  - FILL at the last address produces a single write.
- Command inputs changing while busy have no effect. Latched fill data is immune to later changes of cmd_data.
- Counter width is ADDR_WIDTH+1 internally, or an equivalent explicit last-address compare; termination must not depend on overflow to 0.

Optional Feature:
- Macro TEXT_RAM_WRITER_CLEAR_ON_RESET_EN.
- Defined: on release of reset_n, state enters CLEAR instead of IDLE, so the first 2**ADDR_WIDTH cycles write CLEAR_CHAR to every location with cmd_ready low. cursor=0 at completion. Reset values of we, addr_a and din_a are unchanged.
- Not defined: reset goes directly to IDLE; RAM contents are untouched.

Test Plan:
- Reset/handshake: hold reset_n=0, then release -> we=0, addr_a=0, din_a=0, cursor=0, cmd_ready=1 (macro undefined). With the macro defined -> cmd_ready=0 for 64 cycles and 64 writes of CLEAR_CHAR at addresses 0..63.
- Back-to-back write: SETCUR 62, then WRITE 'A', 'B', 'C' on consecutive cycles -> writes (62,'A'), (63,'B'), (0,'C') on consecutive cycles, cursor=1, cmd_ready never drops.
- Clear: CLEAR with CLEAR_CHAR=0x20 -> cmd_ready=0 for exactly 64 cycles, writes at addresses 0..63 all 0x20, then cursor=0 and cmd_ready=1. cmd_valid held high with WRITE during the sequence -> no extra writes.
- Fill: cursor=5, FILL addr=60 data=0x2A -> writes 0x2A at 60, 61, 62, 63 only, then IDLE with cursor still 5. FILL addr=63 -> exactly one write.
- Reset mid-operation: assert reset_n=0 mid-CLEAR at counter=20, asynchronously between edges -> we=0 immediately. After release -> IDLE, no further writes, cursor=0.
- Data latch: change cmd_data during FILL from 0x2A to 0x55 -> all fill writes remain 0x2A.
